uart_baud_gen: RTL and testbench

//  Programmable UART baud/oversample tick generator; successor to the fixed /638 divider.

---
 rtl/uart_baud_gen.sv | 113 +++++++++++
 tb/tb_uart_baud_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Programmable UART baud/oversample tick generator with runtime divisor, phase re-sync and legacy m_clk.
// Define UART_BAUD_FRAC_EN to add the fractional divisor (frac_in port, frac_q register).
module uart_baud_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 318,
  parameter int unsigned FRAC_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  input  logic             sync_clr,
  output logic [DIV_W-1:0] div_q,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             m_clk
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  if (OVERSAMPLE < 2 || FRAC_W < 1) begin : g_param_check
    $error("uart_baud_gen: OVERSAMPLE must be >= 2 and FRAC_W >= 1");
  end

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] next_div;
  logic [OS_W-1:0]  os_cnt;
  logic             pend;
  logic             stretch;
  logic             wrap;
  logic             apply;
  logic [DIV_W:0]   limit;

  // A write in the same cycle as the apply point takes effect at that point.
  assign next_div = div_wr ? div_in : pend_div;
  assign apply    = (pend | div_wr) & (wrap | sync_clr | ~en);
  // >= rather than == keeps the counter bounded if the divisor shrinks while frozen.
  assign limit    = {1'b0, div_q} + {{DIV_W{1'b0}}, stretch};
  assign wrap     = en & ~sync_clr & ({1'b0, cnt} >= limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      os_cnt   <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      pend     <= 1'b0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      m_clk    <= 1'b0;
    end else begin
      os_tick  <= wrap;
      bit_tick <= wrap & (os_cnt == OS_W'(OVERSAMPLE - 1));

      if (div_wr) pend_div <= div_in;
      if (apply) begin
        div_q <= next_div;
        pend  <= 1'b0;
      end else if (div_wr) begin
        pend  <= 1'b1;
      end

      if (sync_clr) begin
        cnt    <= '0;
        os_cnt <= '0;
      end else if (wrap) begin
        cnt    <= '0;
        m_clk  <= ~m_clk;
        os_cnt <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
      end else if (en) begin
        cnt    <= cnt + DIV_W'(1);
      end
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   frac_sum;

  assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_q};

  // Carry out of the accumulator lengthens the following period by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      frac_q    <= '0;
      pend_frac <= '0;
      frac_acc  <= '0;
      stretch   <= 1'b0;
    end else begin
      if (div_wr) pend_frac <= frac_in;
      if (apply)  frac_q    <= div_wr ? frac_in : pend_frac;
      if (sync_clr) begin
        frac_acc <= '0;
        stretch  <= 1'b0;
      end else if (wrap) begin
        frac_acc <= frac_sum[FRAC_W-1:0];
        stretch  <= frac_sum[FRAC_W];
      end
    end
  end
`else
  assign stretch = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Randomized bench for uart_baud_gen: behavioural period model checked every cycle plus literal timing checks.
module tb_uart_baud_gen;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned DEFAULT_DIV = 318;
  localparam int unsigned FRAC_W      = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             div_wr;
  logic [DIV_W-1:0] div_in;
  logic             sync_clr;
  logic [DIV_W-1:0] div_q;
  logic             os_tick;
  logic             bit_tick;
  logic             m_clk;
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_in;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  uart_baud_gen #(
    .DIV_W(DIV_W), .OVERSAMPLE(OVERSAMPLE), .DEFAULT_DIV(DEFAULT_DIV), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .div_wr(div_wr), .div_in(div_in),
`ifdef UART_BAUD_FRAC_EN
    .frac_in(frac_in),
`endif
    .sync_clr(sync_clr), .div_q(div_q), .os_tick(os_tick), .bit_tick(bit_tick), .m_clk(m_clk)
  );

  always #5 clk = ~clk;

  // Model: elapsed enabled clocks in the current period, tick count since restart, divisor bookkeeping.
  int   el, nsync, mdiv, mpdiv, mfrac, macc, nd, nf, sum;
  logic mpend, mstretch, have, do_apply;
  logic exp_os, exp_bit, exp_m;
`ifdef UART_BAUD_FRAC_EN
  int   mpfrac;
`endif

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      el = 0; nsync = 0; mdiv = DEFAULT_DIV; mpdiv = 0; mfrac = 0; macc = 0;
      mpend = 1'b0; mstretch = 1'b0; exp_os = 1'b0; exp_bit = 1'b0; exp_m = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      mpfrac = 0;
`endif
    end else begin
      have = mpend || div_wr;
      nd   = div_wr ? int'(div_in) : mpdiv;
`ifdef UART_BAUD_FRAC_EN
      nf   = div_wr ? int'(frac_in) : mpfrac;
      if (div_wr) mpfrac = int'(frac_in);
`else
      nf   = 0;
`endif
      if (div_wr) mpdiv = int'(div_in);
      exp_os = 1'b0; exp_bit = 1'b0; do_apply = 1'b0;
      if (sync_clr) begin
        el = 0; nsync = 0; macc = 0; mstretch = 1'b0; do_apply = 1'b1;
      end else if (!en) begin
        do_apply = 1'b1;
      end else if (el >= mdiv + int'(mstretch)) begin
        exp_os   = 1'b1;
        el       = 0;
        nsync++;
        exp_bit  = (nsync % OVERSAMPLE) == 0;
        exp_m    = ~exp_m;
        sum      = macc + mfrac;
        mstretch = sum >= (1 << FRAC_W);
        macc     = sum % (1 << FRAC_W);
        do_apply = 1'b1;
      end else begin
        el++;
      end
      if (do_apply && have) begin
        mdiv = nd; mfrac = nf;
      end
      mpend = have && !do_apply;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      vectors++;
      if (os_tick !== exp_os || bit_tick !== exp_bit || m_clk !== exp_m || div_q !== DIV_W'(mdiv)) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL model cycle %0d: os_tick %b want %b, bit_tick %b want %b, m_clk %b want %b, div_q %0d want %0d",
                   cyc, os_tick, exp_os, bit_tick, exp_bit, m_clk, exp_m, div_q, mdiv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Returns the number of clock edges until os_tick is observed high.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!os_tick && n < budget);
    if (!os_tick) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: no os_tick within %0d cycles", budget);
    end
  endtask

  int n, total, ticks, seen;

  initial begin
    reset = 1'b1; en = 1'b1; div_wr = 1'b0; div_in = '0; sync_clr = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    frac_in = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_os_tick", int'(os_tick), 0);
    chk("reset_bit_tick", int'(bit_tick), 0);
    chk("reset_m_clk", int'(m_clk), 0);
    chk("reset_div_q", int'(div_q), 318);
    reset = 1'b0;

    // Legacy divider behaviour.
    wait_tick(400, n); chk("first_tick_edges", n, 319);
    chk("m_clk_after_first", int'(m_clk), 1);
    wait_tick(400, n); chk("tick_period", n, 319);
    total = 638; ticks = 2;
    while (!bit_tick && ticks < 20) begin
      wait_tick(400, n); total += n; ticks++;
    end
    chk("first_bit_tick_edges", total, 5104);
    chk("m_clk_after_16", int'(m_clk), 0);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(400, n); total += n;
    end
    chk("bit_tick_period", total, 5104);
    chk("bit_tick_on_16th", int'(bit_tick), 1);

    // Mid-period divisor write: old period completes first.
    repeat (100) @(negedge clk);
    div_wr = 1'b1; div_in = 16'd9;
    @(negedge clk);
    div_wr = 1'b0;
    wait_tick(400, n); chk("old_period_finishes", n + 101, 319);
    chk("div_q_applied", int'(div_q), 9);
    wait_tick(50, n); chk("new_period", n, 10);

    // Freeze at cnt=5 for 50 cycles.
    repeat (5) @(negedge clk);
    en = 1'b0; seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (os_tick || bit_tick) seen++;
    end
    chk("ticks_while_disabled", seen, 0);
    en = 1'b1;
    wait_tick(50, n); chk("resume_after_enable", n, 5);

    // Phase re-sync at os_cnt=7.
    ticks = 0;
    while (!bit_tick && ticks < 20) begin
      wait_tick(50, n); ticks++;
    end
    for (int i = 0; i < 7; i++) wait_tick(50, n);
    repeat (3) @(negedge clk);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    chk("no_tick_on_sync", int'(os_tick), 0);
    wait_tick(50, n); chk("sync_restart_edges", n, 10);
    ticks = 1;
    while (!bit_tick && ticks < 40) begin
      wait_tick(50, n); ticks++;
    end
    chk("bit_tick_after_sync", ticks, 16);

    // Divisor write landing on the wrap cycle.
    repeat (9) @(negedge clk);
    div_wr = 1'b1; div_in = 16'd4;
    @(negedge clk);
    div_wr = 1'b0;
    chk("tick_on_wr_wrap", int'(os_tick), 1);
    chk("div_q_wr_wrap", int'(div_q), 4);
    wait_tick(50, n); chk("period_after_wr_wrap", n, 5);

    // Divisor write together with sync_clr.
    repeat (2) @(negedge clk);
    div_wr = 1'b1; div_in = 16'd6; sync_clr = 1'b1;
    @(negedge clk);
    div_wr = 1'b0; sync_clr = 1'b0;
    chk("div_q_wr_sync", int'(div_q), 6);
    wait_tick(50, n); chk("first_after_wr_sync", n, 7);
    wait_tick(50, n); chk("period_after_wr_sync", n, 7);

    // Divisor zero: tick every cycle.
    div_wr = 1'b1; div_in = 16'd0; sync_clr = 1'b1;
    @(negedge clk);
    div_wr = 1'b0; sync_clr = 1'b0;
    wait_tick(10, n); chk("div0_first", n, 1);
    @(negedge clk);
    chk("div0_back_to_back", int'(os_tick), 1);

`ifdef UART_BAUD_FRAC_EN
    // 9 + 8/16: periods alternate 10/11.
    div_wr = 1'b1; div_in = 16'd9; frac_in = 4'd8; sync_clr = 1'b1;
    @(negedge clk);
    div_wr = 1'b0; sync_clr = 1'b0;
    wait_tick(50, n);
    wait_tick(50, n);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(50, n); total += n;
    end
    chk("frac_16_tick_span", total, 168);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 30000; i++) begin
      reset    = ($urandom_range(0, 2999) == 0);
      en       = ($urandom_range(0, 9) != 0);
      div_wr   = ($urandom_range(0, 39) == 0);
      div_in   = DIV_W'($urandom_range(0, 24));
      sync_clr = ($urandom_range(0, 299) == 0);
`ifdef UART_BAUD_FRAC_EN
      frac_in  = FRAC_W'($urandom);
`endif
      @(negedge clk);
    end
    reset = 1'b0; div_wr = 1'b0; sync_clr = 1'b0; en = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
